apb_i2c_csr: RTL and testbench

APB_I2C_CSR -- requirements
Module: apb_i2c_csr

---
 rtl/apb_i2c_csr.sv | 150 +++++++++++++++
 tb/tb_apb_i2c_csr.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_csr.sv
// APB control/status register block for an I2C core: TX push, RX pop,
// CONFIG/TIMEOUT, sticky interrupt status with enables, and programmable wait states.
module apb_i2c_csr #(
  parameter int DW          = 32,
  parameter int AW          = 8,
  parameter int CFG_W       = 14,
  parameter int TMO_W       = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PSELx,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [AW-1:0]    PADDR,
  input  logic [DW-1:0]    PWDATA,
  output logic [DW-1:0]    PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [DW-1:0]    RX_DATA,
  input  logic             TX_FULL,
  input  logic             TX_EMPTY,
  input  logic             RX_EMPTY,
  input  logic             I2C_ERROR,
  output logic             WR_ENA,
  output logic             RD_ENA,
  output logic [DW-1:0]    WRITE_DATA_ON_TX,
  output logic [CFG_W-1:0] CONFIG,
  output logic [TMO_W-1:0] TIMEOUT,
  output logic             IRQ
);

  localparam logic [AW-1:0] OFF_TX    = AW'(8'h00);
  localparam logic [AW-1:0] OFF_RX    = AW'(8'h04);
  localparam logic [AW-1:0] OFF_CFG   = AW'(8'h08);
  localparam logic [AW-1:0] OFF_TMO   = AW'(8'h0C);
  localparam logic [AW-1:0] OFF_STAT  = AW'(8'h10);
  localparam logic [AW-1:0] OFF_INTS  = AW'(8'h14);
  localparam logic [AW-1:0] OFF_INTEN = AW'(8'h18);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [2:0]         int_stat_q, int_stat_d;
  logic [2:0]         int_en_q, int_en_d;
  logic               tx_empty_q, rx_empty_q;
  logic               irq_q, irq_d;

  logic               pready;
  logic               addr_err;
  logic               wr_ok, rd_ok;
  logic [DW-1:0]      rd_mux;
  logic [2:0]         int_set, int_clr;

  assign pready = (state_q == ACCESS) && PSELx && PENABLE && (cnt_q == 3'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (PSELx && !PENABLE) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 3'(WAIT_STATES);
      end
      ACCESS: begin
        if (!PSELx || pready) state_d = IDLE;
        if (cnt_q != 3'd0)    cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address decode also classifies illegal accesses so they can be suppressed.
  always_comb begin
    addr_err = 1'b0;
    rd_mux   = '0;
    case (PADDR)
      OFF_TX:    addr_err = !PWRITE || TX_FULL;
      OFF_RX: begin
        addr_err = PWRITE || RX_EMPTY;
        rd_mux   = RX_DATA;
      end
      OFF_CFG:   rd_mux = DW'(cfg_q);
      OFF_TMO:   rd_mux = DW'(tmo_q);
      OFF_STAT: begin
        addr_err = PWRITE;
        rd_mux   = DW'({TX_FULL, RX_EMPTY, TX_EMPTY});
      end
      OFF_INTS:  rd_mux = DW'(int_stat_q);
      OFF_INTEN: rd_mux = DW'(int_en_q);
      default:   addr_err = 1'b1;
    endcase
  end

  assign wr_ok = pready && !addr_err && PWRITE;
  assign rd_ok = pready && !addr_err && !PWRITE;

  assign PREADY           = pready;
  assign PSLVERR          = pready && addr_err;
  assign WR_ENA           = wr_ok && (PADDR == OFF_TX);
  assign RD_ENA           = rd_ok && (PADDR == OFF_RX);
  assign PRDATA           = rd_ok ? rd_mux : '0;
  assign WRITE_DATA_ON_TX = PWDATA;
  assign CONFIG           = cfg_q;
  assign TIMEOUT          = tmo_q;
  assign IRQ              = irq_q;

  // A set event in the same cycle as a W1C clear keeps the bit set.
  always_comb begin
    cfg_d    = cfg_q;
    tmo_d    = tmo_q;
    int_en_d = int_en_q;
    if (wr_ok && (PADDR == OFF_CFG))   cfg_d    = PWDATA[CFG_W-1:0];
    if (wr_ok && (PADDR == OFF_TMO))   tmo_d    = PWDATA[TMO_W-1:0];
    if (wr_ok && (PADDR == OFF_INTEN)) int_en_d = PWDATA[2:0];
    int_set    = {I2C_ERROR, rx_empty_q & ~RX_EMPTY, ~tx_empty_q & TX_EMPTY};
    int_clr    = (wr_ok && (PADDR == OFF_INTS)) ? PWDATA[2:0] : 3'b000;
    int_stat_d = (int_stat_q & ~int_clr) | int_set;
    irq_d      = |(int_stat_d & int_en_d);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      cfg_q      <= '0;
      tmo_q      <= '0;
      int_stat_q <= 3'b000;
      int_en_q   <= 3'b000;
      tx_empty_q <= 1'b1;
      rx_empty_q <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      tmo_q      <= tmo_d;
      int_stat_q <= int_stat_d;
      int_en_q   <= int_en_d;
      tx_empty_q <= TX_EMPTY;
      rx_empty_q <= RX_EMPTY;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_i2c_csr.sv
// Directed bench for apb_i2c_csr with WAIT_STATES=3: a vector table for the
// register map plus hand sequences for interrupts, abort and mid-transfer reset.
module tb_apb_i2c_csr;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSELx, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA, RX_DATA, WRITE_DATA_ON_TX;
  logic        PREADY, PSLVERR;
  logic        TX_FULL, TX_EMPTY, RX_EMPTY, I2C_ERROR;
  logic        WR_ENA, RD_ENA, IRQ;
  logic [13:0] CONFIG, TIMEOUT;

  int errors = 0;
  int checks = 0;

  logic [31:0] rdata, txData;
  logic        slverr;
  int          waits, wrCnt, rdCnt;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        txFull;
    logic [31:0] expRdata;
    logic        expErr;
    int          expWr;
    int          expRd;
  } vec_t;

  vec_t vecs[20];

  apb_i2c_csr #(.DW(32), .AW(8), .CFG_W(14), .TMO_W(14), .WAIT_STATES(3)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .RX_DATA(RX_DATA), .TX_FULL(TX_FULL),
    .TX_EMPTY(TX_EMPTY), .RX_EMPTY(RX_EMPTY), .I2C_ERROR(I2C_ERROR),
    .WR_ENA(WR_ENA), .RD_ENA(RD_ENA), .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX),
    .CONFIG(CONFIG), .TIMEOUT(TIMEOUT), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one APB transfer starting at posedge+1 and ends at posedge+1 after
  // completion, so consecutive calls are back-to-back on the bus.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                               input logic errOnDone);
    bit done = 0;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    waits = 0; wrCnt = 0; rdCnt = 0; rdata = '0; slverr = 1'b0; txData = '0;
    @(negedge PCLK);
    wrCnt += int'(WR_ENA); rdCnt += int'(RD_ENA);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    while (!done && waits <= 20) begin
      @(negedge PCLK);
      wrCnt += int'(WR_ENA); rdCnt += int'(RD_ENA);
      if (PREADY) begin
        done   = 1;
        rdata  = PRDATA;
        slverr = PSLVERR;
        txData = WRITE_DATA_ON_TX;
        if (errOnDone) I2C_ERROR = 1'b1;
      end else begin
        waits++;
      end
      @(posedge PCLK); #1;
    end
    I2C_ERROR = 1'b0;
    PSELx = 1'b0; PENABLE = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL pready_timeout: got no PREADY, expected PREADY within 20 cycles");
    end
  endtask

  // One SETUP cycle plus WAIT_STATES ACCESS cycles keep PREADY low: 4 low samples.
  task automatic checkXfer(input string name, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] expRdata,
                           input logic expErr, input int expWr, input int expRd);
    applyStimulus(wr, addr, wdata, 1'b0);
    checkOutput({name, ".rdata"},  rdata, expRdata);
    checkOutput({name, ".slverr"}, 32'(slverr), 32'(expErr));
    checkOutput({name, ".waits"},  32'(waits), 32'd4);
    checkOutput({name, ".wrEna"},  32'(wrCnt), 32'(expWr));
    checkOutput({name, ".rdEna"},  32'(rdCnt), 32'(expRd));
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, ".pready"},  32'(PREADY), 32'd0);
    checkOutput({name, ".pslverr"}, 32'(PSLVERR), 32'd0);
    checkOutput({name, ".wrEna"},   32'(WR_ENA), 32'd0);
    checkOutput({name, ".rdEna"},   32'(RD_ENA), 32'd0);
    checkOutput({name, ".irq"},     32'(IRQ), 32'd0);
    checkOutput({name, ".prdata"},  PRDATA, 32'd0);
    checkOutput({name, ".config"},  32'(CONFIG), 32'd0);
    checkOutput({name, ".timeout"}, 32'(TIMEOUT), 32'd0);
  endtask

  initial begin
    PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    RX_DATA = '0; TX_FULL = 1'b0; TX_EMPTY = 1'b0; RX_EMPTY = 1'b1; I2C_ERROR = 1'b0;

    //            wr    addr   wdata         txFull expRdata      err  wr rd
    vecs[0]  = '{1'b0, 8'h08, 32'h0,        1'b0, 32'h3ABC,     1'b0, 0, 0};
    vecs[1]  = '{1'b1, 8'h0C, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 0, 0};
    vecs[2]  = '{1'b0, 8'h0C, 32'h0,        1'b0, 32'h3FFF,     1'b0, 0, 0};
    vecs[3]  = '{1'b0, 8'h1C, 32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
    vecs[4]  = '{1'b1, 8'h04, 32'h55,       1'b0, 32'h0,        1'b1, 0, 0};
    vecs[5]  = '{1'b1, 8'h10, 32'h55,       1'b0, 32'h0,        1'b1, 0, 0};
    vecs[6]  = '{1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
    vecs[7]  = '{1'b1, 8'h00, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 0, 0};
    vecs[8]  = '{1'b1, 8'h00, 32'h12345678, 1'b0, 32'h0,        1'b0, 1, 0};
    vecs[9]  = '{1'b0, 8'h04, 32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
    vecs[10] = '{1'b0, 8'h10, 32'h0,        1'b1, 32'h6,        1'b0, 0, 0};
    vecs[11] = '{1'b0, 8'h10, 32'h0,        1'b0, 32'h2,        1'b0, 0, 0};
    vecs[12] = '{1'b1, 8'h18, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 0, 0};
    vecs[13] = '{1'b0, 8'h18, 32'h0,        1'b0, 32'h7,        1'b0, 0, 0};
    vecs[14] = '{1'b0, 8'h09, 32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
    vecs[15] = '{1'b1, 8'h08, 32'h0000F0F5, 1'b0, 32'h0,        1'b0, 0, 0};
    vecs[16] = '{1'b0, 8'h08, 32'h0,        1'b0, 32'h30F5,     1'b0, 0, 0};
    vecs[17] = '{1'b0, 8'h14, 32'h0,        1'b0, 32'h0,        1'b0, 0, 0};
    vecs[18] = '{1'b1, 8'h18, 32'h0,        1'b0, 32'h0,        1'b0, 0, 0};
    vecs[19] = '{1'b0, 8'h18, 32'h0,        1'b0, 32'h0,        1'b0, 0, 0};

    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checkResetOutputs("reset");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    $display("[TB] wait-state config write");
    checkXfer("cfgWr", 1'b1, 8'h08, 32'h00003ABC, 32'h0, 1'b0, 0, 0);
    checkOutput("cfgPort", 32'(CONFIG), 32'h3ABC);

    $display("[TB] register map vectors");
    for (int i = 0; i < 20; i++) begin
      TX_FULL = vecs[i].txFull;
      checkXfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].expRdata, vecs[i].expErr, vecs[i].expWr, vecs[i].expRd);
      if (vecs[i].expWr != 0) checkOutput($sformatf("vec%0d.txData", i), txData, vecs[i].wdata);
      TX_FULL = 1'b0;
    end
    checkOutput("tmoPort", 32'(TIMEOUT), 32'h3FFF);

    $display("[TB] RX-not-empty interrupt");
    RX_DATA = 32'hA5; RX_EMPTY = 1'b0;
    @(posedge PCLK); #1;
    checkXfer("intStatRxne", 1'b0, 8'h14, 32'h0, 32'h2, 1'b0, 0, 0);
    checkOutput("irqMasked", 32'(IRQ), 32'd0);
    checkXfer("intEnWr", 1'b1, 8'h18, 32'h2, 32'h0, 1'b0, 0, 0);
    checkOutput("irqRxne", 32'(IRQ), 32'd1);
    checkXfer("rxRead", 1'b0, 8'h04, 32'h0, 32'hA5, 1'b0, 0, 1);
    RX_EMPTY = 1'b1;
    checkXfer("w1cRxne", 1'b1, 8'h14, 32'h2, 32'h0, 1'b0, 0, 0);
    checkOutput("irqCleared", 32'(IRQ), 32'd0);
    checkXfer("intStatClr", 1'b0, 8'h14, 32'h0, 32'h0, 1'b0, 0, 0);

    $display("[TB] error set racing W1C");
    I2C_ERROR = 1'b1;
    @(posedge PCLK); #1;
    I2C_ERROR = 1'b0;
    checkXfer("intStatErr", 1'b0, 8'h14, 32'h0, 32'h4, 1'b0, 0, 0);
    applyStimulus(1'b1, 8'h14, 32'h4, 1'b1);
    checkOutput("w1cRace.slverr", 32'(slverr), 32'd0);
    checkXfer("intStatRace", 1'b0, 8'h14, 32'h0, 32'h4, 1'b0, 0, 0);
    checkOutput("irqErrMasked", 32'(IRQ), 32'd0);
    checkXfer("intEnErr", 1'b1, 8'h18, 32'h4, 32'h0, 1'b0, 0, 0);
    checkOutput("irqErr", 32'(IRQ), 32'd1);

    $display("[TB] aborted transfer");
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      checkOutput($sformatf("abort%0d.pslverr", c), 32'(PSLVERR), 32'd0);
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
    end
    PSELx = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("abortTmo", 32'(TIMEOUT), 32'h3FFF);
    checkXfer("abortReadBack", 1'b0, 8'h0C, 32'h0, 32'h3FFF, 1'b0, 0, 0);

    $display("[TB] reset during access");
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h0ABC;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    checkResetOutputs("midReset");
    PSELx = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    checkXfer("postRstWr", 1'b1, 8'h08, 32'h00001357, 32'h0, 1'b0, 0, 0);
    checkXfer("postRstRd", 1'b0, 8'h08, 32'h0, 32'h1357, 1'b0, 0, 0);
    checkOutput("postRstTmo", 32'(TIMEOUT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
